// File: rtl/booth_radix2_sequencer.sv
// booth_radix2_sequencer: iterative radix-2 Booth multiplier driving an external ones-complement stage
module booth_radix2_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o,
  output logic [WIDTH-1:0]   oc_in_o,
  output logic               oc_cin_o,
  input  logic [WIDTH-1:0]   oc_out_i
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q;
  logic [WIDTH-1:0]   m_q, q_q, q_d;
  logic [WIDTH:0]     a_q, a_d, a_sum, addend;
  logic               q1_q, busy_q, done_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] product_q;
  logic               add_op;
  assign oc_cin_o  = (state_q == RUN) & q_q[0] & ~q1_q;
  assign oc_in_o   = m_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = product_q;
  // the complementer returns ~M when subtracting; the carry-in completes the negation
  always_comb begin
    add_op = q_q[0] ^ q1_q;
    addend = add_op ? {oc_out_i[WIDTH-1], oc_out_i} : '0;
    a_sum  = a_q + addend + {{WIDTH{1'b0}}, oc_cin_o};
    a_d    = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_d    = {a_sum[0], q_q[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            m_q     <= multiplicand_i;
            q_q     <= multiplier_i;
            a_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          q1_q  <= q_q[0];
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            product_q <= {a_d[WIDTH-1:0], q_d};
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_radix2_sequencer.sv
// tb_booth_radix2_sequencer: directed and random checks against a plain signed-multiply reference
module tb_booth_radix2_sequencer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [63:0]  mcand = '0, mplier = '0;
  logic         busy, done, oc_cin;
  logic [127:0] product;
  logic [63:0]  oc_in, oc_out;
  int           n_assert = 0, n_fail = 0;
  logic [127:0] last_prod = '0;
  always #5 clk = ~clk;
  // behavioural complementer stage
  assign oc_out = oc_in ^ {64{oc_cin}};
  booth_radix2_sequencer #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .start_i(start), .multiplicand_i(mcand), .multiplier_i(mplier),
    .busy_o(busy), .done_o(done), .product_o(product), .oc_in_o(oc_in), .oc_cin_o(oc_cin),
    .oc_out_i(oc_out)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    return sa * sb;
  endfunction
  task automatic run_op(input logic [63:0] m, input logic [63:0] q, input int poke, input bit hold);
    logic [127:0] exp;
    logic         prev_bit;
    exp = ref_mul(m, q);
    prev_bit = 1'b0;
    mcand = m;
    mplier = q;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    mcand = {$urandom, $urandom};
    mplier = {$urandom, $urandom};
    for (int j = 0; j < 64; j++) begin
      chk("busy_run", 128'(busy), 128'(1));
      chk("done_run", 128'(done), 128'(0));
      chk("prod_held", product, last_prod);
      chk("oc_in", 128'(oc_in), 128'(m));
      chk("oc_cin", 128'(oc_cin), 128'(q[j] & ~prev_bit));
      prev_bit = q[j];
      if (j == poke) begin
        start = 1'b1;
        mcand = {$urandom, $urandom};
        mplier = {$urandom, $urandom};
      end else if (j == poke + 1 && !hold) start = 1'b0;
      tick();
    end
    chk("done_pulse", 128'(done), 128'(1));
    chk("busy_done", 128'(busy), 128'(0));
    chk("oc_cin_done", 128'(oc_cin), 128'(0));
    chk("product", product, exp);
    last_prod = exp;
    tick();
    chk("done_once", 128'(done), 128'(0));
    chk("busy_idle", 128'(busy), 128'(0));
    chk("product_stable", product, exp);
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_product", product, 128'(0));
    chk("rst_oc_cin", 128'(oc_cin), 128'(0));
    chk("rst_oc_in", 128'(oc_in), 128'(0));
    run_op(64'd3, 64'd5, -1, 1'b0);
    chk("p_3x5", product, 128'hF);
    run_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, -1, 1'b0);
    chk("p_m3x5", product, {{124{1'b1}}, 4'h1});
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, -1, 1'b0);
    chk("p_min_sq", product, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, -1, 1'b0);
    chk("p_max_min", product, 128'hC000_0000_0000_0000_8000_0000_0000_0000);
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 10, 1'b0);
    // abort mid-run with reset
    mcand = 64'd11;
    mplier = 64'd13;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_product", product, 128'(0));
    last_prod = '0;
    tick();
    chk("abort_no_done", 128'(done), 128'(0));
    chk("abort_idle", 128'(busy), 128'(0));
    run_op(64'd7, -64'sd9, -1, 1'b1);
    chk("p_7xm9", product, {{120{1'b1}}, 8'hC1});
    run_op({$urandom, $urandom}, {$urandom, $urandom}, -1, 1'b0);
    for (int k = 0; k < 6; k++) run_op({$urandom, $urandom}, {$urandom, $urandom}, -1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
